// File: rtl/mlp_pkg.sv
// Shared types and Q-format helpers for the MLP inference engine.
package mlp_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HID_MAC,
    S_HID_DRAIN,
    S_HID_ACT,
    S_OUT_MAC,
    S_OUT_DRAIN,
    S_OUT_ACT,
    S_WRITE,
    S_DONE
  } state_t;

  // Sized for the longer of the two dot products so neither can overflow.
  function automatic int acc_w(int width, int nf, int nh);
    int k;
    k = (nf > nh) ? nf : nh;
    return 2 * width + $clog2(k + 2);
  endfunction

  function automatic int c_pt(int nf, int nh);
    return nh * (nf + 3) + (nh + 3) + 1;
  endfunction

  function automatic logic signed [31:0] sat_shift(
    logic signed [63:0] v,
    int width,
    int frac
  );
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = v >>> frac;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (s > hi) return 32'(hi);
    if (s < lo) return 32'(lo);
    return 32'(s);
  endfunction

endpackage

// File: rtl/mlp_inference_engine_if.sv
// Control and RAM-port bundle between the engine and its memories.
interface mlp_inference_engine_if #(
  parameter int WIDTH          = 8,
  parameter int X_DEPTH_BITS   = 9,
  parameter int W1_DEPTH_BITS  = 4,
  parameter int W2_DEPTH_BITS  = 2,
  parameter int RES_DEPTH_BITS = 6
);
  logic Start;
  logic Busy;
  logic Done;

  logic                      X_read_en;
  logic [X_DEPTH_BITS-1:0]   X_read_address;
  logic signed [WIDTH-1:0]   X_read_data_out;

  logic                      W1_read_en;
  logic [W1_DEPTH_BITS-1:0]  W1_read_address;
  logic signed [WIDTH-1:0]   W1_read_data_out;

  logic                      W2_read_en;
  logic [W2_DEPTH_BITS-1:0]  W2_read_address;
  logic signed [WIDTH-1:0]   W2_read_data_out;

  logic                      RES_write_en;
  logic [RES_DEPTH_BITS-1:0] RES_write_address;
  logic signed [WIDTH-1:0]   RES_write_data_in;

  modport master (
    input  Start,
    input  X_read_data_out,
    input  W1_read_data_out,
    input  W2_read_data_out,
    output Busy,
    output Done,
    output X_read_en,
    output X_read_address,
    output W1_read_en,
    output W1_read_address,
    output W2_read_en,
    output W2_read_address,
    output RES_write_en,
    output RES_write_address,
    output RES_write_data_in
  );

  modport slave (
    output Start,
    output X_read_data_out,
    output W1_read_data_out,
    output W2_read_data_out,
    input  Busy,
    input  Done,
    input  X_read_en,
    input  X_read_address,
    input  W1_read_en,
    input  W1_read_address,
    input  W2_read_en,
    input  W2_read_address,
    input  RES_write_en,
    input  RES_write_address,
    input  RES_write_data_in
  );
endinterface

// File: rtl/mac_unit.sv
// Signed multiply-accumulate with load-on-first-term and
// shift/saturate/ReLU readout.
module mac_unit
  import mlp_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int FRAC_BITS = 4,
  parameter int ACC_W     = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr,
  input  logic                    relu,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] y
);
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   term;
  logic signed [ACC_W-1:0]   acc;
  logic signed [WIDTH-1:0]   sat;

  assign prod = (2*WIDTH)'(a) * (2*WIDTH)'(b);
  assign term = ACC_W'(prod);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= clr ? term : acc + term;
    end
  end

  assign sat = WIDTH'(sat_shift(64'(acc), WIDTH, FRAC_BITS));
  assign y   = (relu && sat[WIDTH-1]) ? '0 : sat;

endmodule

// File: rtl/mlp_inference_engine.sv
// Two-layer MLP inference engine: one shared MAC, hidden
// results kept in a small register file.
module mlp_inference_engine
  import mlp_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int FRAC_BITS      = 4,
  parameter int N_FEATURES     = 7,
  parameter int N_HIDDEN       = 2,
  parameter int N_POINTS       = 64,
  parameter int ACT_RELU       = 1,
  parameter int X_DEPTH_BITS   = 9,
  parameter int W1_DEPTH_BITS  = 4,
  parameter int W2_DEPTH_BITS  = 2,
  parameter int RES_DEPTH_BITS = 6
) (
  input logic                   clk,
  input logic                   rst,
  mlp_inference_engine_if.master bus
);
  localparam int ACC_W = acc_w(WIDTH, N_FEATURES, N_HIDDEN);
  localparam int MAXK  = (N_FEATURES > N_HIDDEN) ?
                         N_FEATURES : N_HIDDEN;
  localparam int TW    = $clog2(MAXK + 1);
  localparam int HW    = $clog2(N_HIDDEN + 1);
  localparam int PW    = $clog2(N_POINTS + 1);
  localparam logic signed [WIDTH-1:0] ONE =
    WIDTH'(1 << FRAC_BITS);

  state_t                    state;
  logic [TW-1:0]             t;
  logic [HW-1:0]             h;
  logic [PW-1:0]             p;
  logic [X_DEPTH_BITS-1:0]   x_base;
  logic signed [WIDTH-1:0]   hid [N_HIDDEN];

  logic                      busy_q;
  logic                      done_q;
  logic                      wr_en_q;
  logic [RES_DEPTH_BITS-1:0] wr_addr_q;
  logic signed [WIDTH-1:0]   wr_data_q;

  logic                      acc_en_q;
  logic                      first_q;
  logic                      hid_stage_q;
  logic signed [WIDTH-1:0]   hsel_q;
  logic signed [WIDTH-1:0]   hid_sel;

  logic                      hid_mac;
  logic                      out_mac;
  logic                      x_en;
  logic                      relu;
  logic signed [WIDTH-1:0]   mac_a;
  logic signed [WIDTH-1:0]   mac_b;
  logic signed [WIDTH-1:0]   mac_y;

  assign hid_mac = (state == S_HID_MAC);
  assign out_mac = (state == S_OUT_MAC);
  assign x_en    = hid_mac && (t != '0);

  assign bus.X_read_en      = x_en;
  assign bus.X_read_address = x_en ?
    x_base + X_DEPTH_BITS'(t) - X_DEPTH_BITS'(1) : '0;
  assign bus.W1_read_en      = hid_mac;
  assign bus.W1_read_address = hid_mac ?
    W1_DEPTH_BITS'(t) * W1_DEPTH_BITS'(N_HIDDEN) +
    W1_DEPTH_BITS'(h) : '0;
  assign bus.W2_read_en      = out_mac;
  assign bus.W2_read_address = out_mac ?
    W2_DEPTH_BITS'(t) : '0;

  assign bus.Busy              = busy_q;
  assign bus.Done              = done_q;
  assign bus.RES_write_en      = wr_en_q;
  assign bus.RES_write_address = wr_addr_q;
  assign bus.RES_write_data_in = wr_data_q;

  always_comb begin
    hid_sel = '0;
    for (int i = 0; i < N_HIDDEN; i++) begin
      if (int'(t) == i + 1) hid_sel = hid[i];
    end
  end

  // RAM data arrives one cycle after issue, so the operand
  // routing follows the registered copy of the issue state.
  always_comb begin
    mac_a = hsel_q;
    mac_b = bus.W2_read_data_out;
    if (hid_stage_q) begin
      mac_a = bus.X_read_data_out;
      mac_b = bus.W1_read_data_out;
    end
    if (first_q) mac_a = ONE;
  end

  assign relu = (ACT_RELU != 0) && (state == S_HID_ACT);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_en_q    <= 1'b0;
      first_q     <= 1'b0;
      hid_stage_q <= 1'b0;
      hsel_q      <= '0;
    end else begin
      acc_en_q    <= hid_mac || out_mac;
      first_q     <= (t == '0);
      hid_stage_q <= hid_mac;
      hsel_q      <= hid_sel;
    end
  end

  mac_unit #(
    .WIDTH     (WIDTH),
    .FRAC_BITS (FRAC_BITS),
    .ACC_W     (ACC_W)
  ) u_mac (
    .clk  (clk),
    .rst  (rst),
    .en   (acc_en_q),
    .clr  (first_q),
    .relu (relu),
    .a    (mac_a),
    .b    (mac_b),
    .y    (mac_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      t         <= '0;
      h         <= '0;
      p         <= '0;
      x_base    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      for (int i = 0; i < N_HIDDEN; i++) hid[i] <= '0;
    end else begin
      wr_en_q <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (bus.Start) begin
            state  <= S_HID_MAC;
            t      <= '0;
            h      <= '0;
            p      <= '0;
            x_base <= '0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
          end
        end
        S_HID_MAC: begin
          if (t == TW'(N_FEATURES)) begin
            t     <= '0;
            state <= S_HID_DRAIN;
          end else begin
            t <= t + TW'(1);
          end
        end
        S_HID_DRAIN: state <= S_HID_ACT;
        S_HID_ACT: begin
          for (int i = 0; i < N_HIDDEN; i++) begin
            if (int'(h) == i) hid[i] <= mac_y;
          end
          if (h == HW'(N_HIDDEN - 1)) begin
            h     <= '0;
            state <= S_OUT_MAC;
          end else begin
            h     <= h + HW'(1);
            state <= S_HID_MAC;
          end
        end
        S_OUT_MAC: begin
          if (t == TW'(N_HIDDEN)) begin
            t     <= '0;
            state <= S_OUT_DRAIN;
          end else begin
            t <= t + TW'(1);
          end
        end
        S_OUT_DRAIN: state <= S_OUT_ACT;
        S_OUT_ACT: begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= RES_DEPTH_BITS'(p);
          wr_data_q <= mac_y;
          state     <= S_WRITE;
        end
        S_WRITE: begin
          if (p == PW'(N_POINTS - 1)) begin
            state  <= S_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            p      <= p + PW'(1);
            x_base <= x_base + X_DEPTH_BITS'(N_FEATURES);
            state  <= S_HID_MAC;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_inference_engine.sv
// Directed bench for mlp_inference_engine: default, identity
// activation and a 3x4x1 configuration against a small model.
module tb_mlp_inference_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start01 = 1'b0;
  logic start2 = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mlp_inference_engine_if b0 ();
  mlp_inference_engine_if b1 ();
  mlp_inference_engine_if #(.W2_DEPTH_BITS(3)) b2 ();

  assign b0.Start = start01;
  assign b1.Start = start01;
  assign b2.Start = start2;

  mlp_inference_engine dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  mlp_inference_engine #(.ACT_RELU(0)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  mlp_inference_engine #(
    .N_FEATURES    (3),
    .N_HIDDEN      (4),
    .N_POINTS      (5),
    .W2_DEPTH_BITS (3)
  ) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (b2)
  );

  logic signed [7:0] xm  [512];
  logic signed [7:0] w1m [16];
  logic signed [7:0] w2m [8];
  logic signed [7:0] res0 [64];
  logic signed [7:0] res1 [64];
  logic signed [7:0] res2 [64];
  int exp2 [5];

  int nw0 = 0, nw1 = 0, nw2 = 0;
  int bad0 = 0, bad1 = 0, bad2 = 0;
  int la0 = -1, la1 = -1, la2 = -1;

  always @(posedge clk) begin
    if (b0.X_read_en)  b0.X_read_data_out  <= xm[b0.X_read_address];
    if (b0.W1_read_en) b0.W1_read_data_out <= w1m[b0.W1_read_address];
    if (b0.W2_read_en) b0.W2_read_data_out <= w2m[b0.W2_read_address];
    if (b1.X_read_en)  b1.X_read_data_out  <= xm[b1.X_read_address];
    if (b1.W1_read_en) b1.W1_read_data_out <= w1m[b1.W1_read_address];
    if (b1.W2_read_en) b1.W2_read_data_out <= w2m[b1.W2_read_address];
    if (b2.X_read_en)  b2.X_read_data_out  <= xm[b2.X_read_address];
    if (b2.W1_read_en) b2.W1_read_data_out <= w1m[b2.W1_read_address];
    if (b2.W2_read_en) b2.W2_read_data_out <= w2m[b2.W2_read_address];
  end

  always @(posedge clk) begin
    if (b0.RES_write_en) begin
      res0[b0.RES_write_address] <= b0.RES_write_data_in;
      nw0 <= nw0 + 1;
      if (int'(b0.RES_write_address) != 0 &&
          int'(b0.RES_write_address) != la0 + 1) bad0 <= bad0 + 1;
      la0 <= int'(b0.RES_write_address);
    end
    if (b1.RES_write_en) begin
      res1[b1.RES_write_address] <= b1.RES_write_data_in;
      nw1 <= nw1 + 1;
      if (int'(b1.RES_write_address) != 0 &&
          int'(b1.RES_write_address) != la1 + 1) bad1 <= bad1 + 1;
      la1 <= int'(b1.RES_write_address);
    end
    if (b2.RES_write_en) begin
      res2[b2.RES_write_address] <= b2.RES_write_data_in;
      nw2 <= nw2 + 1;
      if (int'(b2.RES_write_address) != 0 &&
          int'(b2.RES_write_address) != la2 + 1) bad2 <= bad2 + 1;
      la2 <= int'(b2.RES_write_address);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load(input int xv, input int w1b, input int w1w,
                      input int w2b, input int w2w);
    for (int i = 0; i < 512; i++) xm[i] = 8'(xv);
    for (int i = 0; i < 16; i++) w1m[i] = (i < 2) ? 8'(w1b) : 8'(w1w);
    for (int i = 0; i < 8; i++) w2m[i] = 8'(0);
    w2m[0] = 8'(w2b);
    w2m[1] = 8'(w2w);
    w2m[2] = 8'(w2w);
  endtask

  // n counts edges from the Start-accepting edge (n = 1).
  task automatic run(input int sel, input int abort_at,
                     input int pulse, output int n);
    n = 0;
    @(negedge clk);
    if (sel == 2) start2 = 1'b1;
    else start01 = 1'b1;
    while (n < 5000) begin
      @(posedge clk);
      #1;
      n++;
      start01 = (sel != 2) && (pulse != 0) && (n % 97 == 0);
      start2 = 1'b0;
      if (n == 1) begin
        check("busy_rise", (sel == 2) ? int'(b2.Busy) : int'(b0.Busy), 1);
        check("done_low", (sel == 2) ? int'(b2.Done) : int'(b0.Done), 0);
      end
      if (n == abort_at) return;
      if ((sel == 2) ? b2.Done : b0.Done) break;
    end
    start01 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic check_res(input int sel, input int exp);
    for (int i = 0; i < 64; i++)
      check($sformatf("res%0d[%0d]", sel, i),
            (sel == 0) ? int'(res0[i]) : int'(res1[i]), exp);
  endtask

  task automatic run01(input int pulse, input int e0, input int e1);
    int n, s0, s1, o0, o1;
    s0 = nw0;
    s1 = nw1;
    o0 = bad0;
    o1 = bad1;
    run(0, 0, pulse, n);
    check("cycles", n, 1665);
    check("writes0", nw0 - s0, 64);
    check("writes1", nw1 - s1, 64);
    check("order", (bad0 - o0) + (bad1 - o1), 0);
    check("last_addr", la0, 63);
    check_res(0, e0);
    check_res(1, e1);
  endtask

  function automatic int sat8(int v);
    return (v > 127) ? 127 : ((v < -128) ? -128 : v);
  endfunction

  initial begin
    int n, s0, s2;
    int acc;
    int hv [4];

    load(16, 0, 1, 0, 16);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", b0.Busy, 0);
    check("rst_done", b0.Done, 0);
    check("rst_en", {b0.X_read_en, b0.W1_read_en,
                     b0.W2_read_en, b0.RES_write_en}, 0);
    @(negedge clk);
    rst = 1'b0;

    // hid = 7, out = 14
    run01(0, 14, 14);

    // hid = -25: ReLU gives 5, identity gives -45
    load(16, -32, 1, 5, 16);
    run01(0, 5, -45);

    // hid = 112, out = +/-224 saturates
    load(16, 0, 16, 0, 16);
    run01(0, 127, 127);
    load(16, 0, 16, 0, -16);
    run01(0, -128, -128);

    // abort mid-run
    load(16, 0, 1, 0, 16);
    run(0, 300, 0, n);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_outs", {b0.Busy, b0.Done, b0.RES_write_en,
                         b0.X_read_en, b0.W1_read_en, b0.W2_read_en}, 0);
    check("abort_addr", int'(b0.X_read_address) +
                        int'(b0.W1_read_address), 0);
    s0 = nw0;
    @(negedge clk);
    rst = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    check("abort_nowrite", nw0 - s0, 0);
    check("abort_idle", b0.Busy, 0);
    run01(0, 14, 14);

    // Start pulses while busy are ignored; Done holds
    load(16, -32, 1, 5, 16);
    run01(1, 5, -45);
    s0 = nw0;
    repeat (20) @(posedge clk);
    #1;
    check("done_hold", b0.Done, 1);
    check("done_busy", b0.Busy, 0);
    check("done_nowrite", nw0 - s0, 0);
    load(16, 0, 16, 0, 16);
    run01(0, 127, 127);

    // 3 features, 4 hidden, 5 points vs model
    for (int i = 0; i < 15; i++) xm[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 16; i++) w1m[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 5; i++) w2m[i] = 8'($urandom_range(0, 255));
    for (int q = 0; q < 5; q++) begin
      for (int j = 0; j < 4; j++) begin
        acc = int'(w1m[j]) * 16;
        for (int k = 0; k < 3; k++)
          acc += int'(xm[q*3+k]) * int'(w1m[(k+1)*4+j]);
        hv[j] = sat8(acc >>> 4);
        if (hv[j] < 0) hv[j] = 0;
      end
      acc = int'(w2m[0]) * 16;
      for (int j = 0; j < 4; j++) acc += hv[j] * int'(w2m[j+1]);
      exp2[q] = sat8(acc >>> 4);
    end
    s2 = nw2;
    s0 = bad2;
    run(2, 0, 0, n);
    check("cycles2", n, 161);
    check("writes2", nw2 - s2, 5);
    check("order2", bad2 - s0, 0);
    check("last2", la2, 4);
    for (int q = 0; q < 5; q++)
      check($sformatf("res2[%0d]", q), int'(res2[q]), exp2[q]);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mlp_inference_engine.md
Name: mlp_inference_engine

Overview:
- Parametrised two-layer MLP inference engine (input -> N_HIDDEN hidden nodes -> 1 output) over N_POINTS datapoints of N_FEATURES signed fixed-point features.
- Biases come from the weight RAMs, not ports.
- Uses one time-multiplexed MAC; hidden results are held in an internal register file.
- Sits between the AXI-stream loader (fills X/W1/W2 RAMs) and the result drain (reads RES RAM). Supersedes the fixed 2-hidden-node engine.

Parameters:
WIDTH, 8, bits per data/weight word, signed two's complement
FRAC_BITS, 4, fractional bits of the Q format, for both data and weights
N_FEATURES, 7, inputs per datapoint
N_HIDDEN, 2, hidden nodes, 1..16
N_POINTS, 64, datapoints per run
ACT_RELU, 1, 1: ReLU on hidden outputs; 0: identity
X_DEPTH_BITS, 9, X RAM address bits (>= clog2(N_POINTS*N_FEATURES))
W1_DEPTH_BITS, 4, W1 RAM address bits (>= clog2((N_FEATURES+1)*N_HIDDEN))
W2_DEPTH_BITS, 2, W2 RAM address bits (>= clog2(N_HIDDEN+1))
RES_DEPTH_BITS, 6, RES RAM address bits (>= clog2(N_POINTS))

Ports:
clk  in  1  single clock; all logic on posedge
rst  in  1  synchronous, active-high reset
Start  in  1  level; sampled only in IDLE/DONE
Busy  out  1  high from the cycle after Start acceptance until DONE
Done  out  1  high in DONE; held until Start or rst
X_read_en  out  1  X RAM read enable
X_read_address  out  X_DEPTH_BITS  row-major: p*N_FEATURES+k
X_read_data_out  in  WIDTH  valid the cycle after the enabled read
W1_read_en  out  1
W1_read_address  out  W1_DEPTH_BITS  row-major: r*N_HIDDEN+h; row 0 = hidden biases
W1_read_data_out  in  WIDTH  1-cycle latency
W2_read_en  out  1
W2_read_address  out  W2_DEPTH_BITS  entry 0 = output bias; entries 1..N_HIDDEN = weights
W2_read_data_out  in  WIDTH  1-cycle latency
RES_write_en  out  1  single-cycle pulse per result
RES_write_address  out  RES_DEPTH_BITS  datapoint index p
RES_write_data_in  out  WIDTH  output result

Behaviour:
- Reset (synchronous rst=1):
  - State IDLE; all outputs 0; read enables low; point/node/term counters 0; hidden register file cleared.
  - rst mid-run aborts immediately; no further RES writes. Next Start restarts at p=0.
- States: IDLE -> HID_MAC -> HID_DRAIN -> HID_ACT -> (next h: HID_MAC | OUT_MAC) -> OUT_DRAIN -> OUT_ACT -> WRITE -> (next p: HID_MAC | DONE).
  - DONE -> HID_MAC on Start=1 (new run).
  - Start=1 in IDLE -> HID_MAC, p=h=0.
  - Start is ignored in all other states.
- MAC term t=0..K is issued in consecutive MAC cycles.
  - Hidden: K=N_FEATURES.
    - t=0 reads the bias W1[h]; the X term is treated as 1.0 (1<<FRAC_BITS).
    - t>=1 reads X[p*N_FEATURES+t-1] and W1[t*N_HIDDEN+h].
  - Output: K=N_HIDDEN.
    - t=0 reads the bias W2[0].
    - t>=1 reads W2[t] and takes the X term from hid[t-1].
  - Accumulation lags issue by one cycle; DRAIN accumulates the final term.
- Arithmetic:
  - Signed WIDTH x WIDTH products; accumulator width 2*WIDTH+clog2(N_FEATURES+2); no intermediate overflow.
  - ACT: arithmetic right shift by FRAC_BITS, then saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Hidden stage only: if ACT_RELU=1, negative values become 0.
  - Result stored to hid[h] (hidden) or the output register (output).
- WRITE: RES_write_en=1 for exactly one cycle with address p and data = output register.
  - No write occurs at any other time.
  - After p=N_POINTS-1, go to DONE: Done=1, Busy=0.
- Timing:
  - Per-datapoint cost C_PT = N_HIDDEN*(N_FEATURES+3) + (N_HIDDEN+3) + 1 (default 26 cycles).
  - Done rises exactly N_POINTS*C_PT + 1 cycles after the Start-accepting edge (default 1665).
- Read enables are high only in MAC cycles that issue a read for that RAM.
  - X reads issue only for t>=1 of the hidden stage.
  - Addresses never exceed the ranges above.

Decomposition:
- Package mlp_pkg: state enum, Q-format helpers (sat_shift function), accumulator width constant, C_PT localparam function.
- Sub-module mac_unit: signed multiply-accumulate with clear/load-bias, accumulate-enable and sat/shift/ReLU output, parametrised by WIDTH/FRAC_BITS/ACC_W.
- Top level contains the FSM, counters, address generation and hid register file.

Test Plan:
1. Defaults; all X=16 (1.0); W1 weights=1, W1 biases=0; W2 weights=16, W2 bias=0 -> every RES[p]=14; 64 writes to addresses 0..63; Done at cycle 1665.
2. As 1, but W1 biases=-32, ACT_RELU=1, W2 bias=5 -> hid=-25 clamped to 0, RES=5. Same stimulus with ACT_RELU=0 -> RES=-45 (0xD3).
3. W1 weights=16, W2 weights=16, biases 0 -> hidden 7.0=112 in range; output 224 saturates -> RES=127. Negated W2 -> RES=-128.
4. Assert rst at cycle 300 of a run -> no further RES writes, outputs 0 next cycle. Start -> full run from p=0 with correct results.
5. Pulse Start repeatedly while Busy -> no effect, single run, cycle count unchanged. Done held until Start, then new run begins.
6. N_HIDDEN=4, N_FEATURES=3, N_POINTS=5 with random X/W vs reference model -> bit-exact RES; Done at 5*(4*6+7+1)+1=161 cycles.
